// File: rtl/el2_pkg.sv
// Shared decode-side types for the GPR snapshot walker.
package el2_pkg;

    // Walker FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } el2_gpr_snap_state_t;

    // One streamed entry: GPR index plus its value.
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } el2_gpr_snap_entry_t;

    localparam int unsigned GprSnapEntryW = $bits(el2_gpr_snap_entry_t);

    // One signature step: rotate left by one, then fold in the new value.
    function automatic logic [31:0] el2_gpr_snap_sig_step(logic [31:0] sig, logic [31:0] data);
        return {sig[30:0], sig[31]} ^ data;
    endfunction

endpackage

// File: rtl/el2_dec_gpr_snap_if.sv
// Regfile read port plus the valid/ready snapshot stream.
interface el2_dec_gpr_snap_if;

    logic [4:0]  gpr_raddr;
    logic [31:0] gpr_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    // Walker side: drives the read address and the stream.
    modport master (
        output gpr_raddr,
        input  gpr_rdata,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_data
    );

    // Regfile / consumer side.
    modport slave (
        input  gpr_raddr,
        output gpr_rdata,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_data
    );

endinterface

// File: rtl/el2_gpr_snap_fifo.sv
// Two-entry FIFO for snapshot entries; push and pop may coincide, flush empties it.
module el2_gpr_snap_fifo
    import el2_pkg::*;
#(
    parameter int unsigned WIDTH = GprSnapEntryW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;

    // Occupancy next state; caller never pushes when full without a pop.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (flush) begin
            cnt_d = 2'd0;
        end
    end

    // Storage and pointers; flush takes priority over any push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= wdata;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/el2_dec_gpr_snap.sv
// Walks a GPR index range through one read port, streams {idx, value} pairs,
// holds decode frozen during the walk and accumulates a rotate-XOR signature.
module el2_dec_gpr_snap
    import el2_pkg::*;
#(
    parameter int unsigned FIRST_IDX = 1,
    parameter int unsigned LAST_IDX  = 31
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    el2_dec_gpr_snap_if.master        bus,
    output logic                      freeze_req,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [31:0]               signature
);

    localparam logic [4:0] FirstIdx = 5'(FIRST_IDX);
    localparam logic [4:0] LastIdx  = 5'(LAST_IDX);

    el2_gpr_snap_state_t state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [31:0]         sig_q, sig_d;
    logic                aborted_q, aborted_d;

    el2_gpr_snap_entry_t wentry;
    el2_gpr_snap_entry_t head;
    logic                push;
    logic                pop;
    logic                flush;
    logic                full;
    logic                empty;
    logic                active;
    logic [4:0]          raddr;

    assign active = (state_q != StIdle);
    assign pop    = ~empty & bus.out_ready;
    assign wentry = '{idx: idx_q, data: bus.gpr_rdata};

    el2_gpr_snap_fifo #(
        .WIDTH(GprSnapEntryW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .wdata(wentry),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    // Next-state, capture and signature logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sig_d     = sig_q;
        aborted_d = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        raddr     = 5'd0;

        // A transfer that coincides with abort still counts toward the signature.
        if (pop) begin
            sig_d = el2_gpr_snap_sig_step(sig_q, head.data);
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    idx_d   = FirstIdx;
                    sig_d   = 32'd0;
                    flush   = 1'b1;
                end
            end
            StRun: begin
                raddr = idx_q;
                if (!full || pop) begin
                    push = 1'b1;
                    // Index stops at LAST_IDX so it can never wrap.
                    if (idx_q == LastIdx) begin
                        state_d = StDrain;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StDrain: begin
                raddr = LastIdx;
                // Not full and not empty means exactly one entry remains.
                if (pop && !full) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && active) begin
            state_d   = StIdle;
            push      = 1'b0;
            flush     = 1'b1;
            aborted_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= FirstIdx;
            sig_q     <= 32'd0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sig_q     <= sig_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.gpr_raddr = raddr;
    assign bus.out_valid = ~empty;
    assign bus.out_idx   = head.idx;
    assign bus.out_data  = head.data;
    assign busy          = active;
    assign freeze_req    = active;
    assign done          = (state_q == StDone);
    assign aborted       = aborted_q;
    assign signature     = sig_q;

endmodule

// File: tb/tb_el2_dec_gpr_snap.sv
// Scoreboard bench for the GPR snapshot walker: default range and a single-entry range.
module tb_el2_dec_gpr_snap;
    import el2_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, abort0, freeze0, busy0, done0, aborted0;
    logic [31:0] sig0;
    logic        start1, abort1, freeze1, busy1, done1, aborted1;
    logic [31:0] sig1;

    el2_dec_gpr_snap_if if0 ();
    el2_dec_gpr_snap_if if1 ();

    logic [31:0] regs0 [32];
    assign if0.gpr_rdata = regs0[if0.gpr_raddr];
    assign if1.gpr_rdata = 32'hFFFF_FFFF;

    el2_dec_gpr_snap #(.FIRST_IDX(1), .LAST_IDX(31)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .bus(if0),
        .freeze_req(freeze0), .busy(busy0), .done(done0), .aborted(aborted0),
        .signature(sig0)
    );

    el2_dec_gpr_snap #(.FIRST_IDX(5), .LAST_IDX(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .bus(if1),
        .freeze_req(freeze1), .busy(busy1), .done(done1), .aborted(aborted1),
        .signature(sig1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int xfer0    = 0;
    el2_gpr_snap_entry_t exp0_q[$];
    el2_gpr_snap_entry_t exp1_q[$];
    el2_gpr_snap_entry_t e0, e1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference signature: rotate left one bit, XOR value, over the walk in order.
    function automatic logic [31:0] fold0(input int first, input int last);
        logic [31:0] s = 32'd0;
        for (int j = first; j <= last; j++) begin
            s = ((s << 1) | (s >> 31)) ^ regs0[j];
        end
        return s;
    endfunction

    task automatic fill_random0();
        for (int j = 0; j < 32; j++) regs0[j] = $urandom;
    endtask

    task automatic push_walk0();
        for (int j = 1; j <= 31; j++) exp0_q.push_back('{idx: 5'(j), data: regs0[j]});
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic start_walk0();
        start0 = 1'b1;
        go();
        start0 = 1'b0;
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_freeze"}, freeze0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_aborted"}, aborted0, 0);
        check({tag, "_sig"}, sig0, 0);
        check({tag, "_valid"}, if0.out_valid, 0);
        check({tag, "_idx"}, if0.out_idx, 0);
        check({tag, "_data"}, if0.out_data, 0);
        check({tag, "_raddr"}, if0.gpr_raddr, 0);
    endtask

    task automatic wait_done0(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done0) begin
                got = 1'b1;
                break;
            end
        end
        check("done0_timeout", 32'(got), 1);
        go();
    endtask

    // Monitors: compare each transfer against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0 && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
            if (exp0_q.size() == 0) begin
                check("xfer0_extra", 32'(exp0_q.size()), 1);
            end else begin
                e0 = exp0_q.pop_front();
                check("xfer0_idx", if0.out_idx, e0.idx);
                check("xfer0_data", if0.out_data, e0.data);
            end
            xfer0++;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
            if (exp1_q.size() == 0) begin
                check("xfer1_extra", 32'(exp1_q.size()), 1);
            end else begin
                e1 = exp1_q.pop_front();
                check("xfer1_idx", if1.out_idx, e1.idx);
                check("xfer1_data", if1.out_data, e1.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int x_before;
        rst = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        if0.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        for (int j = 0; j < 32; j++) regs0[j] = 32'h1000_0000 + 32'(j);
        #1 rst = 1'b1;
        #2;
        check_zero0("reset0");
        check("reset1_busy", busy1, 0);
        check("reset1_valid", if1.out_valid, 0);
        check("reset1_sig", sig1, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        go();

        // Test 1: default range, ready high, exact latency.
        push_walk0();
        start_walk0();
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            check("t1_busy", busy0, 32'(k <= 33));
            check("t1_freeze", freeze0, 32'(k <= 33));
            check("t1_done", done0, 32'(k == 33));
            check("t1_valid", if0.out_valid, 32'(k >= 2 && k <= 32));
        end
        check("t1_sig", sig0, fold0(1, 31));
        check("t1_left", 32'(exp0_q.size()), 0);
        go();

        // Test 2: random data, ready toggling every cycle.
        fill_random0();
        push_walk0();
        start_walk0();
        begin
            bit got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if0.out_ready = ~i[0];
                @(negedge clk);
                if (done0) begin
                    got = 1'b1;
                    break;
                end
                go();
            end
            check("t2_done_timeout", 32'(got), 1);
        end
        go();
        if0.out_ready = 1'b1;
        check("t2_sig", sig0, fold0(1, 31));
        check("t2_left", 32'(exp0_q.size()), 0);

        // Test 3: consumer stalled for 20 cycles after start.
        fill_random0();
        push_walk0();
        if0.out_ready = 1'b0;
        start_walk0();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check("t3_valid", if0.out_valid, 1);
                check("t3_idx", if0.out_idx, 1);
                check("t3_data", if0.out_data, regs0[1]);
            end
            if (k >= 3) check("t3_raddr", if0.gpr_raddr, 3);
            if (k < 20) go();
        end
        go();
        if0.out_ready = 1'b1;
        wait_done0(100);
        check("t3_sig", sig0, fold0(1, 31));
        check("t3_left", 32'(exp0_q.size()), 0);

        // Test 4: abort coinciding with the 10th transfer.
        fill_random0();
        push_walk0();
        x_before = xfer0;
        start_walk0();
        repeat (10) @(posedge clk);
        #1 abort0 = 1'b1;
        go();
        abort0 = 1'b0;
        @(negedge clk);
        check("t4_busy", busy0, 0);
        check("t4_valid", if0.out_valid, 0);
        check("t4_aborted", aborted0, 1);
        check("t4_done", done0, 0);
        check("t4_xfers", 32'(xfer0 - x_before), 10);
        check("t4_sig", sig0, fold0(1, 10));
        exp0_q.delete();
        for (int k = 0; k < 5; k++) begin
            go();
            @(negedge clk);
            check("t4_aborted_pulse", aborted0, 0);
            check("t4_no_done", done0, 0);
            check("t4_sig_hold", sig0, fold0(1, 10));
        end
        go();
        push_walk0();
        start_walk0();
        @(negedge clk);
        check("t4_restart_sig", sig0, 0);
        check("t4_restart_busy", busy0, 1);
        wait_done0(100);
        check("t4_restart_final", sig0, fold0(1, 31));
        check("t4_left", 32'(exp0_q.size()), 0);

        // Test 5: single-entry range on the second instance.
        exp1_q.push_back('{idx: 5'd5, data: 32'hFFFF_FFFF});
        start1 = 1'b1;
        go();
        start1 = 1'b0;
        @(negedge clk);
        check("t5_busy", busy1, 1);
        check("t5_valid_t1", if1.out_valid, 0);
        check("t5_raddr", if1.gpr_raddr, 5);
        go();
        @(negedge clk);
        check("t5_valid_t2", if1.out_valid, 1);
        check("t5_done_t2", done1, 0);
        go();
        @(negedge clk);
        check("t5_done_t3", done1, 1);
        check("t5_sig", sig1, 32'hFFFF_FFFF);
        check("t5_valid_t3", if1.out_valid, 0);
        go();
        @(negedge clk);
        check("t5_idle", busy1, 0);
        check("t5_done_t4", done1, 0);
        check("t5_left", 32'(exp1_q.size()), 0);
        go();
        start1 = 1'b1;
        abort1 = 1'b1;
        go();
        start1 = 1'b0;
        abort1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_sa_busy", busy1, 0);
            check("t5_sa_aborted", aborted1, 0);
            check("t5_sa_valid", if1.out_valid, 0);
            check("t5_sa_sig", sig1, 32'hFFFF_FFFF);
            go();
        end

        // Test 6: reset while draining the final entry.
        fill_random0();
        push_walk0();
        start_walk0();
        repeat (31) @(posedge clk);
        #1 if0.out_ready = 1'b0;
        @(negedge clk);
        check("t6_busy", busy0, 1);
        check("t6_valid", if0.out_valid, 1);
        check("t6_idx", if0.out_idx, 31);
        check("t6_raddr", if0.gpr_raddr, 31);
        go();
        @(negedge clk);
        check("t6_still_busy", busy0, 1);
        #2 rst = 1'b1;
        #1;
        check_zero0("t6_rst");
        exp0_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        go();
        if0.out_ready = 1'b1;
        fill_random0();
        push_walk0();
        start_walk0();
        wait_done0(100);
        check("t6_sig", sig0, fold0(1, 31));
        check("t6_left", 32'(exp0_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/el2_dec_gpr_snap.md
Name: el2_dec_gpr_snap

Overview:
- Read-side initiator for the decode GPR file: on command, walks a contiguous GPR index range through one regfile read port.
- Streams each {index, value} pair to a consumer (debug snapshot / lockstep compare) over a valid/ready interface.
- Holds a freeze request to decode so no GPR writes occur mid-walk, and accumulates a 32-bit rotate-XOR signature of the streamed values.

Parameters:
- FIRST_IDX, 1, first GPR index read (0..31)
- LAST_IDX, 31, last GPR index read (FIRST_IDX..31)

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a walk; sampled only in IDLE
- abort  input  1  terminate a walk immediately
- gpr_raddr  output  5  regfile read address
- gpr_rdata  input  32  regfile read data, combinational from gpr_raddr in the same cycle
- freeze_req  output  1  decode must block all GPR writes while high
- out_valid  output  1  stream entry valid
- out_ready  input  1  consumer accepts entry
- out_idx  output  5  GPR index of entry
- out_data  output  32  GPR value of entry
- busy  output  1  walk in progress
- done  output  1  one-cycle pulse at completion
- aborted  output  1  one-cycle pulse on abort of an active walk
- signature  output  32  running signature

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values:
  - All outputs 0.
  - FSM in IDLE, index counter = FIRST_IDX.
  - Buffer empty, signature 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 moves to RUN.
  - On that transition: index = FIRST_IDX, signature cleared to 0, buffer emptied.
  - start=1 and abort=1 in the same cycle: abort wins, stay in IDLE, no aborted pulse.
- RUN:
  - gpr_raddr = index.
  - When the buffer is not full, or a pop occurs this cycle, push {index, gpr_rdata} and increment index.
  - The push of LAST_IDX moves to DRAIN.
- DRAIN:
  - gpr_raddr holds LAST_IDX; no pushes.
  - Moves to DONE in the cycle the final entry is popped.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - signature holds its final value until the next start.
- busy = freeze_req = (state != IDLE).
  - freeze_req is registered: high from the cycle after start is accepted, through the DONE cycle inclusive.
- Buffer:
  - 2-entry FIFO with simultaneous push and pop allowed, so throughput is 1 entry/cycle.
  - out_valid = (count != 0); out_idx/out_data come from the head entry.
- Handshake:
  - An entry transfers when out_valid & out_ready.
  - Once out_valid is high, head contents are stable until the transfer.
  - out_valid never drops without a transfer, except on abort or rst.
- Signature: on each transfer, signature <= {signature[30:0], signature[31]} ^ out_data.
- Latency:
  - start accepted at cycle T: busy at T+1, first capture at T+1, first out_valid at T+2.
  - With out_ready held high: last transfer at T+1+N, done at T+2+N, where N = LAST_IDX-FIRST_IDX+1.
- Back-pressure: with out_ready low and the buffer full, RUN stalls, holding index and gpr_raddr constant.
- Abort:
  - abort=1 in RUN, DRAIN or DONE: next cycle is IDLE, buffer flushed (out_valid=0), aborted=1 for one cycle, no done.
  - signature keeps its partial value.
  - abort in IDLE has no effect.
- start while busy: ignored.
- rst mid-walk: every state and output returns to its reset value asynchronously.
- Index counter: 5-bit. It never exceeds LAST_IDX, and no wrap past 31 is possible by parameter constraint.

Decomposition:
- Shared package el2_pkg adds:
  - el2_gpr_snap_state_t, enum of IDLE/RUN/DRAIN/DONE
  - el2_gpr_snap_entry_t, packed struct {idx[4:0], data[31:0]}
- One natural sub-module: el2_gpr_snap_fifo.
  - 2-entry, width = $bits(el2_gpr_snap_entry_t).
  - Ports push/pop/flush/full/empty; asynchronous active-high reset.

Test Plan:
- Defaults, regfile model xj = 32'h1000_0000+j, out_ready=1, start at T -> 31 transfers with idx 1..31 and data matching on consecutive cycles T+2..T+32; done only at T+33; freeze_req high T+1..T+33.
- Same run, out_ready toggling 1010… -> all 31 entries delivered in order with no duplicates or loss; gpr_raddr stable during stalls; final signature equals the software rotate-XOR model.
- out_ready=0 for 20 cycles after start -> out_valid high with idx=1 held stable; buffer holds idx 1,2; gpr_raddr held at 3; release -> idx 1..31 in order.
- abort during RUN at the 10th transfer -> next cycle busy=0, out_valid=0, aborted=1 for one cycle, done never asserts, signature frozen; a new start clears signature and restarts at idx 1.
- FIRST_IDX=LAST_IDX=5, all-ones data, one start -> single entry idx=5; signature=32'hFFFF_FFFF; done two cycles after the transfer-ready cycle; start+abort in the same IDLE cycle -> nothing happens.
- rst asserted mid-DRAIN -> all outputs 0 immediately; after release, start works normally.
